// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared constants for the pwm fade sequencer.
// State encoding, datapath widths and the tick-period helper.
package pwm_fade_pkg;

  localparam int DUTY_W = 8;
  localparam int HOLD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int tick_period(
    input int clk_freq,
    input int step_hz
  );
    return clk_freq / step_hz;
  endfunction

endpackage

// File: rtl/fade_step.sv
// fade_step: next duty for one channel, moving toward target
// by at most step, never past it (9-bit math, no wrap).
module fade_step
  import pwm_fade_pkg::*;
(
  input  logic [DUTY_W-1:0] cur_i,
  input  logic [DUTY_W-1:0] tgt_i,
  input  logic [DUTY_W-1:0] step_i,
  output logic [DUTY_W-1:0] next_o
);

  logic [DUTY_W:0] cur9;
  logic [DUTY_W:0] tgt9;
  logic [DUTY_W:0] stp9;
  logic [DUTY_W:0] diff9;
  logic [DUTY_W:0] amt9;
  logic [DUTY_W:0] sum9;
  logic            up;
  logic            unused_msb;

  // Clamp the step to the remaining distance, then move.
  always_comb begin
    cur9  = {1'b0, cur_i};
    tgt9  = {1'b0, tgt_i};
    stp9  = {1'b0, step_i};
    up    = (tgt9 >= cur9);
    diff9 = up ? (tgt9 - cur9) : (cur9 - tgt9);
    amt9  = (stp9 < diff9) ? stp9 : diff9;
    sum9  = up ? (cur9 + amt9) : (cur9 - amt9);
    {unused_msb, next_o} = sum9;
  end

endmodule

// File: rtl/pwm_fade_seq.sv
// pwm_fade_seq: ramps CHANNELS duty values to a target, holds, reports.
// Optional PWM_FADE_BREATHE_EN adds a breathe input for up/down looping.
module pwm_fade_seq
  import pwm_fade_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int STEP_HZ  = 1000,
  parameter int CHANNELS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
`ifdef PWM_FADE_BREATHE_EN
  input  logic                       breathe,
`endif
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [DUTY_W*CHANNELS-1:0] cmd_target,
  input  logic [DUTY_W-1:0]          cmd_step,
  input  logic [HOLD_W-1:0]          cmd_hold,
  output logic [DUTY_W*CHANNELS-1:0] duty,
  output logic                       busy,
  output logic                       done_pulse
);

  localparam int PERIOD = tick_period(CLK_FREQ, STEP_HZ);
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
  localparam int DW = DUTY_W * CHANNELS;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     duty_q, duty_d;
  logic [DW-1:0]     tgt_q, tgt_d;
  logic [DUTY_W-1:0] step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic              live_q;
  logic              tick;
  logic              accept;
  logic [DW-1:0]     wt;
  logic [DW-1:0]     nxt;
  logic              at_tgt;

`ifdef PWM_FADE_BREATHE_EN
  logic phase_q, phase_d;
  assign wt = phase_q ? '0 : tgt_q;
`else
  assign wt = tgt_q;
`endif

  assign cmd_ready  = enable && live_q && (state_q == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign at_tgt     = (duty_q == wt);
  assign duty       = duty_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    fade_step u_step (
      .cur_i  (duty_q[c*DUTY_W +: DUTY_W]),
      .tgt_i  (wt[c*DUTY_W +: DUTY_W]),
      .step_i (step_q),
      .next_o (nxt[c*DUTY_W +: DUTY_W])
    );
  end

  // Free-running tick divider, frozen while disabled.
  always_comb begin
    tick  = enable && (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Sequencer next state: accept, ramp on ticks, hold, complete.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
    phase_d = phase_q;
`endif
    if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tgt_d   = cmd_target;
            step_d  = (cmd_step == '0) ? 8'd1 : cmd_step;
            hold_d  = cmd_hold;
            state_d = ST_RAMP;
`ifdef PWM_FADE_BREATHE_EN
            phase_d = 1'b0;
`endif
          end
        end
        ST_RAMP: begin
          if (at_tgt) begin
            if (hold_q == '0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_HOLD;
              hcnt_d  = hold_q;
            end
          end else if (tick) begin
            duty_d = nxt;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            if (hcnt_q == HOLD_W'(1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
`ifdef PWM_FADE_BREATHE_EN
              if (breathe) begin
                state_d = ST_RAMP;
                phase_d = ~phase_q;
              end
`endif
            end else begin
              hcnt_d = hcnt_q - 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      live_q  <= 1'b0;
`ifdef PWM_FADE_BREATHE_EN
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
      live_q  <= 1'b1;
`ifdef PWM_FADE_BREATHE_EN
      phase_q <= phase_d;
`endif
    end
  end

endmodule
